// File: rtl/adiabatic_pkg.sv
// Shared types and the ramp-level helper for the adiabatic power-clock sequencer.
package adiabatic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  // Interval of a phase within its 4-interval period, encoded as (idx - phase) mod 4.
  typedef enum logic [1:0] {
    EVAL  = 2'd0,
    HOLD  = 2'd1,
    RECOV = 2'd2,
    WAIT  = 2'd3
  } ivl_t;

  // Ramp level for an active phase given its interval and the sub-interval count.
  function automatic int unsigned level_of(ivl_t ivl, int unsigned sub, int unsigned int_cyc);
    case (ivl)
      EVAL:    return sub + 32'd1;
      HOLD:    return int_cyc;
      RECOV:   return int_cyc - 32'd1 - sub;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/adiabatic_phase_slot.sv
// One power-clock phase: tracks whether it has started or parked and decodes
// its ramp level and digital clock pair from the shared master counters.
module adiabatic_phase_slot
  import adiabatic_pkg::*;
#(
  parameter int INT_CYC = 4,
  parameter int LVL_W   = 3,
  parameter int SUB_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       idx,
  input  logic [SUB_W-1:0] sub,
  input  logic [1:0]       pidx,
  input  logic             start_en,
  input  logic             drain,
  input  logic             clr,
  output logic [LVL_W-1:0] level,
  output logic             clkpos,
  output logic             clkneg,
  output logic             hold_valid,
  output logic             park_req,
  output logic             parked
);

  logic started_q;
  logic parked_q;
  logic first_eval;
  logic sub_last;
  logic active;
  ivl_t ivl;

  assign ivl        = ivl_t'(idx - pidx);
  assign sub_last   = (sub == SUB_W'(INT_CYC - 1));
  // The very first evaluate cycle counts as active so the ramp starts without delay.
  assign first_eval = start_en && !started_q && (idx == pidx) && (sub == '0);
  assign active     = (started_q && !parked_q) || first_eval;
  // While draining, a phase parks once it is idle: never started, waiting, or at the end of recover.
  assign park_req   = drain && !parked_q &&
                      (!started_q || (ivl == WAIT) || ((ivl == RECOV) && sub_last));
  assign parked     = parked_q;

  // Started/parked flags; cleared when the master leaves IDLE for a new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      started_q <= 1'b0;
      parked_q  <= 1'b0;
    end else if (clr) begin
      started_q <= 1'b0;
      parked_q  <= 1'b0;
    end else begin
      if (first_eval) started_q <= 1'b1;
      if (park_req)   parked_q  <= 1'b1;
    end
  end

  // Level and clock decode; inactive phases sit at level 0.
  always_comb begin
    level      = '0;
    hold_valid = 1'b0;
    if (active) begin
      level      = LVL_W'(level_of(ivl, 32'(sub), INT_CYC));
      hold_valid = (ivl == HOLD);
    end
    clkpos = (level > LVL_W'(INT_CYC / 2));
    clkneg = ~clkpos;
  end

endmodule

// File: rtl/adiabatic_pclk_gen.sv
// Multi-phase trapezoidal power-clock sequencer: master IDLE/RUN/DRAIN FSM,
// shared interval counters and one phase slot per power-clock phase.
module adiabatic_pclk_gen
  import adiabatic_pkg::*;
#(
  parameter int NPHASE  = 4,
  parameter int INT_CYC = 4,
  parameter int LVL_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic [NPHASE*LVL_W-1:0] level,
  output logic [NPHASE-1:0]       clkpos,
  output logic [NPHASE-1:0]       clkneg,
  output logic [NPHASE-1:0]       hold_valid,
  output logic                    busy,
  output logic [CNT_W-1:0]        cycle_cnt
);

  localparam int SUB_W = $clog2(INT_CYC);

  fsm_t             state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q;
  logic             go;
  logic             sub_last;
  logic             all_parked;
  logic             cnt_inc;
  logic [NPHASE-1:0] park_req;
  logic [NPHASE-1:0] parked;

  assign go         = (state_q == IDLE) && start && !stop;
  assign sub_last   = (sub_q == SUB_W'(INT_CYC - 1));
  assign all_parked = &(parked | park_req);
  // Phase 0 is always started once the master runs, so only parking can suppress a count.
  assign cnt_inc    = (state_q != IDLE) && (idx_q == 2'd2) && sub_last && !parked[0];
  assign busy       = (state_q != IDLE);
  assign cycle_cnt  = cnt_q;

  // State, master counters and completed-period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sub_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN:   if (all_parked) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Master counters run in RUN and DRAIN and sit at zero in IDLE, ready for the next start.
  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (state_q == IDLE) begin
      sub_d = '0;
      idx_d = '0;
    end else if (sub_last) begin
      sub_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      sub_d = sub_q + 1'b1;
    end
  end

  for (genvar p = 0; p < NPHASE; p++) begin : g_slot
    adiabatic_phase_slot #(
      .INT_CYC (INT_CYC),
      .LVL_W   (LVL_W),
      .SUB_W   (SUB_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .idx        (idx_q),
      .sub        (sub_q),
      .pidx       (2'(p)),
      .start_en   (state_q == RUN),
      .drain      (state_q == DRAIN),
      .clr        (go),
      .level      (level[p*LVL_W +: LVL_W]),
      .clkpos     (clkpos[p]),
      .clkneg     (clkneg[p]),
      .hold_valid (hold_valid[p]),
      .park_req   (park_req[p]),
      .parked     (parked[p])
    );
  end

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Self-checking bench for adiabatic_pclk_gen: scoreboard of per-cycle expected
// outputs from a timing model, plus reset, corner and randomized invariant checks.
module tb_adiabatic_pclk_gen;

  localparam int NPHASE  = 4;
  localparam int INT_CYC = 4;
  localparam int LVL_W   = 3;
  localparam int CNT_W   = 16;
  localparam int PER     = 4 * INT_CYC;

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [NPHASE*LVL_W-1:0] level;
  logic [NPHASE-1:0]       clkpos, clkneg, hold_valid;
  logic                    busy;
  logic [CNT_W-1:0]        cycle_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [NPHASE*LVL_W-1:0] lvl;
    logic [NPHASE-1:0]       hv;
    logic [NPHASE-1:0]       cp;
    logic                    bsy;
    logic [CNT_W-1:0]        cnt;
  } exp_t;

  exp_t sb[$];

  adiabatic_pclk_gen #(
    .NPHASE (NPHASE), .INT_CYC (INT_CYC), .LVL_W (LVL_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .stop (stop),
    .level (level), .clkpos (clkpos), .clkneg (clkneg),
    .hold_valid (hold_valid), .busy (busy), .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Position of phase p within its period at cycle n (T1 = first RUN cycle), -1 if not yet started.
  function automatic int phase_m(int p, int n);
    int t;
    t = n - 1 - p * INT_CYC;
    if (t < 0) return -1;
    return t % PER;
  endfunction

  function automatic int level_from_m(int m);
    if (m < 0)           return 0;
    if (m < INT_CYC)     return m + 1;
    if (m < 2 * INT_CYC) return INT_CYC;
    if (m < 3 * INT_CYC) return 3 * INT_CYC - 1 - m;
    return 0;
  endfunction

  // Last cycle at which phase p is still unparked when stop is high during cycle stop_n.
  function automatic int park_end(int p, int stop_n);
    int d, t, m;
    d = stop_n + 1;
    t = d - 1 - p * INT_CYC;
    if (t <= 0) return d - 1;
    m = t % PER;
    if (m >= 3 * INT_CYC) return d - 1;
    return d + (3 * INT_CYC - 1 - m);
  endfunction

  function automatic exp_t expect_at(int n, int stop_n, int base_cnt);
    exp_t e;
    int   m, lv, bend, c, cnt;
    e.lvl = '0; e.hv = '0; e.cp = '0;
    bend = stop_n + 1;
    for (int p = 0; p < NPHASE; p++) begin
      m = phase_m(p, n);
      if (stop_n > 0 && n > park_end(p, stop_n)) m = -1;
      lv = level_from_m(m);
      e.lvl[p*LVL_W +: LVL_W] = LVL_W'(lv);
      e.hv[p] = (m >= INT_CYC) && (m < 2 * INT_CYC);
      e.cp[p] = (lv > INT_CYC / 2);
      if (stop_n > 0 && park_end(p, stop_n) > bend) bend = park_end(p, stop_n);
    end
    e.bsy = (stop_n == 0) || (n <= bend);
    cnt = base_cnt;
    for (int k = 0; k < 8; k++) begin
      c = 3 * INT_CYC + PER * k;
      if (c < n && (stop_n == 0 || c <= park_end(0, stop_n))) cnt++;
    end
    e.cnt = CNT_W'(cnt);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Start a run, optionally stop / re-pulse start, and score ncyc cycles against the model.
  task automatic run_seq(input string name, input int stop_n, input int extra_start_n,
                         input int ncyc, input int base_cnt);
    exp_t e;
    for (int n = 1; n <= ncyc; n++) sb.push_back(expect_at(n, stop_n, base_cnt));
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      e = sb.pop_front();
      total_cnt += 5;
      if (level !== e.lvl)
        $display("FAIL %s level T%0d: got %h want %h", name, n, level, e.lvl);
      else pass_cnt++;
      if (hold_valid !== e.hv)
        $display("FAIL %s hold_valid T%0d: got %b want %b", name, n, hold_valid, e.hv);
      else pass_cnt++;
      if (clkpos !== e.cp || clkneg !== ~e.cp)
        $display("FAIL %s clkpos/clkneg T%0d: got %b/%b want %b/%b", name, n, clkpos, clkneg, e.cp, ~e.cp);
      else pass_cnt++;
      if (busy !== e.bsy)
        $display("FAIL %s busy T%0d: got %b want %b", name, n, busy, e.bsy);
      else pass_cnt++;
      if (cycle_cnt !== e.cnt)
        $display("FAIL %s cycle_cnt T%0d: got %0d want %0d", name, n, cycle_cnt, e.cnt);
      else pass_cnt++;
      stop  = (n == stop_n);
      start = (n == extra_start_n);
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [CNT_W-1:0] want_cnt);
    total_cnt++;
    if (level !== '0 || clkpos !== '0 || clkneg !== '1 || hold_valid !== '0 ||
        busy !== 1'b0 || cycle_cnt !== want_cnt)
      $display("FAIL %s: got level=%h clkpos=%b clkneg=%b hv=%b busy=%b cnt=%0d want 0/0/1111/0/0/%0d",
               name, level, clkpos, clkneg, hold_valid, busy, cycle_cnt, want_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_state", '0);
  endtask

  task automatic test_run();
    do_reset();
    run_seq("run", 0, 0, 34, 0);
  endtask

  task automatic test_drain();
    do_reset();
    run_seq("drain", 6, 0, 20, 0);
  endtask

  task automatic test_start_in_drain();
    do_reset();
    run_seq("start_in_drain", 6, 8, 22, 0);
  endtask

  // Restart straight after a drain: parked flags must clear and the count must carry on.
  task automatic test_back_to_back();
    run_seq("back_to_back", 0, 0, 14, 1);
  endtask

  task automatic test_rst_mid(input int rst_at);
    do_reset();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (rst_at - 1) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b1 || cycle_cnt !== CNT_W'((rst_at + 3) / PER))
      $display("FAIL rst_mid_pre T%0d: got busy=%b cnt=%0d want 1/%0d", rst_at, busy, cycle_cnt, (rst_at + 3) / PER);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle_outputs("rst_mid", '0);
  endtask

  task automatic test_start_stop_same();
    do_reset();
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_idle_outputs("start_stop_same", '0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [NPHASE*LVL_W-1:0] prev_lvl;
    logic                    rst_edge;
    logic [NPHASE-1:0]       rise;
    int                      a, b, q;
    logic                    ok_d, ok_adj, ok_cn, ok_cp;
    do_reset();
    prev_lvl = level;
    for (int k = 0; k < 1000; k++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      rst_edge = rst;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      ok_d = 1'b1; ok_adj = 1'b1; ok_cp = 1'b1;
      for (int p = 0; p < NPHASE; p++) begin
        a = int'(level[p*LVL_W +: LVL_W]);
        b = int'(prev_lvl[p*LVL_W +: LVL_W]);
        if (!rst_edge && (a - b > 1 || b - a > 1)) ok_d = 1'b0;
        rise[p] = !rst_edge && (a > b);
        if (clkpos[p] !== (a > INT_CYC / 2)) ok_cp = 1'b0;
      end
      for (int p = 0; p < NPHASE; p++) begin
        q = (p + 1) % NPHASE;
        if (q != p && rise[p] && rise[q]) ok_adj = 1'b0;
      end
      ok_cn = (clkneg === ~clkpos);
      total_cnt += 4;
      if (!ok_d) $display("FAIL rand_delta k=%0d: level %h after %h, step over 1", k, level, prev_lvl);
      else pass_cnt++;
      if (!ok_adj) $display("FAIL rand_adjacent_eval k=%0d: level %h after %h, adjacent phases both rising", k, level, prev_lvl);
      else pass_cnt++;
      if (!ok_cn) $display("FAIL rand_clkneg k=%0d: clkneg %b clkpos %b want complement", k, clkneg, clkpos);
      else pass_cnt++;
      if (!ok_cp) $display("FAIL rand_clkpos k=%0d: clkpos %b for level %h", k, clkpos, level);
      else pass_cnt++;
      prev_lvl = level;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    test_reset();
    test_run();
    test_drain();
    test_start_in_drain();
    test_back_to_back();
    test_rst_mid(7);
    test_rst_mid(20);
    test_start_stop_same();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
